ln_stats_stage1: RTL and testbench

Statistics stage directly upstream of the affine/normalization stage in the LayerNorm datapath. It accepts one row of COUNT signed 8-bit activations and buffers them while accumulating sum and sum-of-squares. It then computes mean, standard deviation (iterative integer square root) and the alpha range code. Finally it replays the row as mean-subtracted 9-bit samples, with mean/std/alpha held stable, as the input stream for the downstream affine stage.

---
 rtl/ln_stats_stage1.sv | 115 +++++++++++
 tb/tb_ln_stats_stage1.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ln_stats_stage1.sv
// ln_stats_stage1: buffers one row, derives mean/std/alpha, then replays the row mean-subtracted
module ln_stats_stage1 #(
  parameter int COUNT      = 128,
  parameter int CNT_WIDTH  = 8,
  parameter int LOG2_COUNT = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic signed [7:0]  i_x,
  output logic               o_ready,
  output logic               o_valid,
  output logic signed [8:0]  o_x_norm,
  output logic signed [21:0] o_mean,
  output logic        [7:0]  o_std,
  output logic        [1:0]  o_alpha,
  output logic               o_S1_done
);
  typedef enum logic [1:0] {ACCUM, CALC, SQRT, STREAM} state_t;
  state_t state, state_n;
  logic signed [7:0]           row_buf [COUNT];
  logic        [CNT_WIDTH-1:0] cnt;
  logic signed [21:0]          sum;
  logic        [31:0]          sumsq;
  logic signed [7:0]           m;
  logic        [15:0]          rad;
  logic        [9:0]           rem;
  logic        [7:0]           q;
  logic signed [8:0]           x_hold;
  logic                        last, sqrt_last, ge;
  logic signed [15:0]          sq;
  logic signed [7:0]           m_c;
  logic        [31:0]          ex2_c;
  logic        [15:0]          mm_c, var_c;
  logic signed [32:0]          diff_c;
  logic        [11:0]          rem_n, trial;
  logic        [7:0]           root_n;
  logic signed [8:0]           xn;
  assign last      = cnt == CNT_WIDTH'(COUNT - 1);
  assign sqrt_last = cnt == CNT_WIDTH'(7);
  assign sq        = i_x * i_x;
  assign m_c       = 8'(sum >>> LOG2_COUNT);
  assign ex2_c     = sumsq >> LOG2_COUNT;
  assign mm_c      = 16'(m_c * m_c);
  assign diff_c    = $signed({1'b0, ex2_c}) - $signed({17'b0, mm_c});
  assign var_c     = diff_c[32] ? '0 : (|diff_c[31:16] ? '1 : diff_c[15:0]);
  // restoring root: bring down two radicand bits, try appending a 1 to the partial root
  assign rem_n     = {rem, rad[15:14]};
  assign trial     = {2'b00, q, 2'b01};
  assign ge        = rem_n >= trial;
  assign root_n    = {q[6:0], ge};
  assign xn        = {row_buf[cnt[LOG2_COUNT-1:0]][7], row_buf[cnt[LOG2_COUNT-1:0]]} - {m[7], m};
  assign o_ready   = state == ACCUM;
  assign o_valid   = state == STREAM;
  assign o_x_norm  = o_valid ? xn : x_hold;
  assign o_S1_done = o_valid && last;
  always_comb begin
    state_n = state;
    case (state)
      ACCUM:   state_n = i_valid && last ? CALC : ACCUM;
      CALC:    state_n = SQRT;
      SQRT:    state_n = sqrt_last ? STREAM : SQRT;
      default: state_n = last ? ACCUM : STREAM;
    endcase
  end
  always_ff @(posedge i_clk) state <= i_rst ? ACCUM : state_n;
  always_ff @(posedge i_clk)
    if (o_ready && i_valid) row_buf[cnt[LOG2_COUNT-1:0]] <= i_x;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      sum     <= '0;
      sumsq   <= '0;
      m       <= '0;
      rad     <= '0;
      rem     <= '0;
      q       <= '0;
      x_hold  <= '0;
      o_mean  <= '0;
      o_std   <= '0;
      o_alpha <= '0;
    end else begin
      case (state)
        ACCUM: if (i_valid) begin
          sum   <= sum + 22'(i_x);
          sumsq <= sumsq + {16'b0, sq};
          cnt   <= last ? '0 : cnt + 1'b1;
        end
        CALC: begin
          m      <= m_c;
          rad    <= var_c;
          rem    <= '0;
          q      <= '0;
          o_mean <= sum;
          sum    <= '0;
          sumsq  <= '0;
        end
        SQRT: begin
          rad <= rad << 2;
          rem <= 10'(ge ? rem_n - trial : rem_n);
          q   <= root_n;
          cnt <= sqrt_last ? '0 : cnt + 1'b1;
          if (sqrt_last) begin
            o_std   <= root_n;
            o_alpha <= |root_n[7:6] ? 2'd3 : root_n[5] ? 2'd2 : root_n[4] ? 2'd1 : 2'd0;
          end
        end
        default: begin
          x_hold <= xn;
          cnt    <= last ? '0 : cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ln_stats_stage1.sv
// tb_ln_stats_stage1: directed rows with a scoreboard of expected stream samples
module tb_ln_stats_stage1;
  logic               i_clk = 0, i_rst = 1, i_valid = 0;
  logic signed [7:0]  i_x = 0;
  logic               o_ready, o_valid, o_S1_done;
  logic signed [8:0]  o_x_norm;
  logic signed [21:0] o_mean;
  logic        [7:0]  o_std;
  logic        [1:0]  o_alpha;
  typedef struct {
    logic signed [8:0]  xn;
    logic signed [21:0] mean;
    logic        [7:0]  std;
    logic        [1:0]  alpha;
    logic               done;
  } exp_t;
  exp_t sb[$];
  exp_t last_e;
  int total = 0, bad = 0;
  int row[128];
  ln_stats_stage1 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x),
    .o_ready(o_ready), .o_valid(o_valid), .o_x_norm(o_x_norm), .o_mean(o_mean),
    .o_std(o_std), .o_alpha(o_alpha), .o_S1_done(o_S1_done)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input longint obs, input longint exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  function automatic void push_row();
    int s = 0, q2 = 0, m, ex2, v, r = 0;
    exp_t e;
    foreach (row[i]) begin
      s += row[i];
      q2 += row[i] * row[i];
    end
    m = s >>> 7;
    ex2 = q2 >>> 7;
    v = ex2 - m * m;
    if (v < 0) v = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    if (r > 255) r = 255;
    e.mean = 22'(s);
    e.std = 8'(r);
    e.alpha = r < 16 ? 2'd0 : r < 32 ? 2'd1 : r < 64 ? 2'd2 : 2'd3;
    foreach (row[i]) begin
      e.xn = 9'(row[i] - m);
      e.done = i == 127;
      sb.push_back(e);
    end
    last_e = e;
  endfunction
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      if (o_valid) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL stream_extra observed=o_valid expected=idle");
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("x_norm", o_x_norm, e.xn);
          chk("done", o_S1_done, e.done);
          chk("mean", o_mean, e.mean);
          chk("std", o_std, e.std);
          chk("alpha", o_alpha, e.alpha);
        end
      end else if (o_S1_done) chk("done_idle", o_S1_done, 0);
    end
  end
  task automatic feed(input int n, input bit gap, input bit hold);
    int k = 0;
    while (!o_ready && k < 400) begin
      @(posedge i_clk); #1;
      k++;
    end
    chk("ready_wait", o_ready, 1);
    for (int i = 0; i < n; i++) begin
      while (gap && $urandom_range(1, 100) <= 50) begin
        i_valid = 0;
        i_x = 8'($urandom);
        @(posedge i_clk); #1;
      end
      i_valid = 1;
      i_x = 8'(row[i]);
      @(posedge i_clk); #1;
    end
    i_valid = hold;
    i_x = 8'd99;
  endtask
  task automatic run_row(input bit gap, input bit hold);
    int n = 0, k = 0;
    feed(128, gap, hold);
    push_row();
    while (!o_valid && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("latency", n, 10);
    while (!o_S1_done && k < 400) begin
      @(negedge i_clk);
      k++;
    end
    i_valid = 0;
    @(posedge i_clk); #1;
    chk("drain", sb.size(), 0);
    chk("ready_after", o_ready, 1);
    chk("valid_after", o_valid, 0);
    chk("xnorm_hold", o_x_norm, last_e.xn);
    chk("mean_hold", o_mean, last_e.mean);
  endtask
  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rst = 0;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_xnorm", o_x_norm, 0);
    chk("rst_mean", o_mean, 0);
    chk("rst_std", o_std, 0);
    chk("rst_alpha", o_alpha, 0);
    chk("rst_done", o_S1_done, 0);
    foreach (row[i]) row[i] = 5;
    run_row(0, 0);
    chk("const_mean", o_mean, 640);
    chk("const_std", o_std, 0);
    foreach (row[i]) row[i] = i % 2 ? -10 : 10;
    run_row(0, 0);
    chk("alt_mean", o_mean, 0);
    chk("alt_std", o_std, 10);
    chk("alt_alpha", o_alpha, 0);
    foreach (row[i]) row[i] = i - 64;
    run_row(0, 0);
    chk("ramp_mean", o_mean, -64);
    chk("ramp_std", o_std, 36);
    chk("ramp_alpha", o_alpha, 2);
    foreach (row[i]) row[i] = i < 64 ? -128 : 127;
    run_row(0, 0);
    chk("ext_mean", o_mean, -64);
    chk("ext_std", o_std, 127);
    chk("ext_alpha", o_alpha, 3);
    foreach (row[i]) row[i] = 5;
    run_row(1, 1);
    chk("gap_mean", o_mean, 640);
    chk("gap_std", o_std, 0);
    foreach (row[i]) row[i] = i % 2 ? -10 : 10;
    run_row(0, 0);
    chk("after_hold_std", o_std, 10);
    foreach (row[i]) row[i] = 7;
    feed(50, 0, 0);
    @(posedge i_clk); #1 i_rst = 1;
    @(posedge i_clk); #1 i_rst = 0;
    foreach (row[i]) row[i] = 3;
    run_row(0, 0);
    chk("abort_mean", o_mean, 384);
    chk("abort_std", o_std, 0);
    foreach (row[i]) row[i] = i - 64;
    feed(128, 0, 0);
    push_row();
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge i_clk);
    repeat (20) @(negedge i_clk);
    @(posedge i_clk); #1 i_rst = 1;
    @(posedge i_clk); #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_done", o_S1_done, 0);
    chk("mid_rst_mean", o_mean, 0);
    i_rst = 0;
    sb.delete();
    repeat (200) @(posedge i_clk);
    #1 chk("mid_rst_idle", o_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
